// File: rtl/ppi_pkg.sv
// Shared encodings for the strobed PPI data port.
package ppi_pkg;

    localparam logic MODE_BASIC   = 1'b0;
    localparam logic MODE_STROBED = 1'b1;

    localparam logic DIR_OUT = 1'b0;
    localparam logic DIR_IN  = 1'b1;

    typedef enum logic [1:0] {
        I_EMPTY = 2'd0,
        I_STB   = 2'd1,
        I_FULL  = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_FULL = 2'd1,
        O_ACK  = 2'd2
    } out_state_t;

endpackage

// File: rtl/ppi_sync_edge.sv
// Two-flop synchroniser for an idle-high handshake pin, with registered
// one-cycle rise/fall pulses. The pulse flop doubles as the second stage,
// so a pulse is visible after the second edge and acted on at the third.
module ppi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    // Synchronise the pin and register edge pulses from the two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            rise <= s1 & ~s2;
            fall <= ~s1 & s2;
        end
    end

endmodule

// File: rtl/ppi_strobed_port.sv
// PPI data port: Mode 0 latched I/O, Mode 1 strobed I/O with STB/IBF and
// OBF/ACK handshakes, interrupt request and sticky overrun flag.
//
// state   | meaning
// I_EMPTY | input buffer empty, waiting for strobe fall
// I_STB   | data captured, strobe still low
// I_FULL  | strobe released, interrupt raised, waiting for CPU read
// O_IDLE  | output buffer empty
// O_FULL  | CPU wrote data, waiting for acknowledge fall
// O_ACK   | acknowledge low, waiting for its rise to raise interrupt
module ppi_strobed_port #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             port_en,
    input  logic             mode,
    input  logic             dir,
    input  logic             inte,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic             pad_oe,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             overrun
);
    import ppi_pkg::*;

    logic             stb_rise, stb_fall, ack_rise, ack_fall;
    logic [WIDTH-1:0] pad_d1, pad_d2;
    logic [WIDTH-1:0] in_latch, out_latch;
    logic             mode_q, dir_q, ctrl_chg;
    logic             intr_req, overrun_q;
    in_state_t        in_state, in_next;
    out_state_t       out_state, out_next;

    logic strobed_in, strobed_out;
    logic in_capture, rd_coincident, in_release, in_raise;
    logic out_load, out_wr, out_ackf, out_ackr;

    ppi_sync_edge u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (stb_n),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    ppi_sync_edge u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ack_n),
        .rise  (ack_rise),
        .fall  (ack_fall)
    );

    assign ctrl_chg    = (mode != mode_q) | (dir != dir_q);
    assign strobed_in  = port_en & (mode == MODE_STROBED) & (dir == DIR_IN);
    assign strobed_out = port_en & (mode == MODE_STROBED) & (dir == DIR_OUT);

    // A read coinciding with a new strobe loses to the capture so no data is dropped.
    assign in_capture    = strobed_in & stb_fall;
    assign rd_coincident = cpu_rd & (in_state == I_FULL);
    assign in_release    = strobed_in & rd_coincident & ~stb_fall;
    assign in_raise      = strobed_in & stb_rise & (in_state == I_STB);

    // Likewise a CPU write takes priority over an acknowledge edge.
    assign out_load = port_en & (dir == DIR_OUT) & cpu_wr;
    assign out_wr   = strobed_out & cpu_wr;
    assign out_ackf = strobed_out & ack_fall & (out_state == O_FULL) & ~cpu_wr;
    assign out_ackr = strobed_out & ack_rise & (out_state == O_ACK) & ~cpu_wr;

    // FSM state registers; a mode/dir change forces both back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state  <= I_EMPTY;
            out_state <= O_IDLE;
        end else if (ctrl_chg) begin
            in_state  <= I_EMPTY;
            out_state <= O_IDLE;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
        end
    end

    // Next-state logic for the input and output handshakes.
    always_comb begin
        in_next  = in_state;
        out_next = out_state;
        if (in_capture)      in_next = I_STB;
        else if (in_raise)   in_next = I_FULL;
        else if (in_release) in_next = I_EMPTY;
        if (out_wr)          out_next = O_FULL;
        else if (out_ackf)   out_next = O_ACK;
        else if (out_ackr)   out_next = O_IDLE;
    end

    // Handshake flag outputs decoded from state.
    always_comb begin
        ibf     = (in_state != I_EMPTY);
        obf_n   = (out_state != O_FULL);
        intr    = intr_req & inte;
        overrun = overrun_q;
    end

    // Pin data pipeline, control copies, latches, interrupt and overrun flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_d1    <= '0;
            pad_d2    <= '0;
            mode_q    <= MODE_BASIC;
            dir_q     <= DIR_OUT;
            in_latch  <= '0;
            out_latch <= '0;
            intr_req  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pad_d1 <= pad_in;
            pad_d2 <= pad_d1;
            mode_q <= mode;
            dir_q  <= dir;
            if (ctrl_chg) begin
                in_latch  <= '0;
                out_latch <= '0;
                intr_req  <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                if (in_capture) in_latch  <= pad_d2;
                if (out_load)   out_latch <= cpu_wdata;

                if (in_release)                       intr_req <= 1'b0;
                else if (in_capture && rd_coincident) intr_req <= 1'b0;
                else if (in_raise)                    intr_req <= 1'b1;
                else if (out_wr)                      intr_req <= 1'b0;
                else if (out_ackr)                    intr_req <= 1'b1;

                if (in_release)
                    overrun_q <= 1'b0;
                else if (in_capture && ibf && !rd_coincident)
                    overrun_q <= 1'b1;
            end
        end
    end

    assign pad_oe  = port_en & ~dir;
    assign pad_out = out_latch;

    // Read-back mux: output latch, live pins (Mode 0) or input latch (Mode 1).
    always_comb begin
        cpu_rdata = in_latch;
        if (dir == DIR_OUT)           cpu_rdata = out_latch;
        else if (mode == MODE_BASIC)  cpu_rdata = pad_d2;
    end

endmodule

// File: tb/tb_ppi_strobed_port.sv
// Directed bench for ppi_strobed_port: handshakes, overrun, coincident events,
// control change and Mode 0 latency.
module tb_ppi_strobed_port;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             port_en, mode, dir, inte, cpu_wr, cpu_rd;
    logic [WIDTH-1:0] cpu_wdata, cpu_rdata, pad_in, pad_out;
    logic             pad_oe, stb_n, ack_n, ibf, obf_n, intr, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    ppi_strobed_port #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .port_en   (port_en),
        .mode      (mode),
        .dir       (dir),
        .inte      (inte),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe),
        .stb_n     (stb_n),
        .ack_n     (ack_n),
        .ibf       (ibf),
        .obf_n     (obf_n),
        .intr      (intr),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; port_en = 1'b0; mode = 1'b0; dir = 1'b1; inte = 1'b0;
        cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = '0; pad_in = '0;
        stb_n = 1'b1; ack_n = 1'b1;
        tick(2);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_pad_out", pad_out, 0);
        check("rst_pad_oe", pad_oe, 0);
        check("rst_ibf", ibf, 0);
        check("rst_obf_n", obf_n, 1);
        check("rst_intr", intr, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(1);
        dir = 1'b0; #1;
        check("oe_disabled", pad_oe, 0);
        port_en = 1'b1; #1;
        check("oe_enabled", pad_oe, 1);

        // Mode 1 input handshake
        mode = 1'b1; dir = 1'b1; inte = 1'b1; pad_in = 8'hA5;
        tick(2);
        check("m1_oe_in", pad_oe, 0);
        stb_n = 1'b0;
        tick(2);
        check("ibf_early", ibf, 0);
        tick(1);
        check("ibf_set", ibf, 1);
        check("rdata_a5", cpu_rdata, 8'hA5);
        tick(1);
        stb_n = 1'b1;
        tick(2);
        check("intr_early", intr, 0);
        tick(1);
        check("intr_set", intr, 1);
        cpu_rd = 1'b1; #1;
        check("rd_data_a5", cpu_rdata, 8'hA5);
        tick(1);
        cpu_rd = 1'b0;
        check("rd_ibf_clr", ibf, 0);
        check("rd_intr_clr", intr, 0);

        // Overrun: second strobe while buffer full
        pad_in = 8'h11; stb_n = 1'b0; tick(3);
        stb_n = 1'b1; tick(3);
        check("ovr_first_full", intr, 1);
        pad_in = 8'h3C; stb_n = 1'b0; tick(3);
        check("ovr_rdata", cpu_rdata, 8'h3C);
        check("ovr_flag", overrun, 1);
        check("ovr_ibf", ibf, 1);
        stb_n = 1'b1; tick(3);
        cpu_rd = 1'b1; tick(1); cpu_rd = 1'b0;
        check("ovr_rd_ibf", ibf, 0);
        check("ovr_rd_clr", overrun, 0);

        // cpu_rd coincident with stb fall: capture wins
        pad_in = 8'h77; stb_n = 1'b0; tick(3);
        stb_n = 1'b1; tick(3);
        check("coin_in_full", ibf, 1);
        pad_in = 8'hC3; stb_n = 1'b0; tick(2);
        cpu_rd = 1'b1; tick(1); cpu_rd = 1'b0;
        check("coin_in_ibf", ibf, 1);
        check("coin_in_data", cpu_rdata, 8'hC3);
        check("coin_in_ovr", overrun, 0);
        check("coin_in_intr", intr, 0);
        stb_n = 1'b1; tick(3);
        cpu_rd = 1'b1; tick(1); cpu_rd = 1'b0;
        check("coin_in_drain", ibf, 0);

        // Mode 1 output handshake
        dir = 1'b0; inte = 1'b0; tick(2);
        cpu_wdata = 8'h5A; cpu_wr = 1'b1; tick(1); cpu_wr = 1'b0;
        check("out_pad", pad_out, 8'h5A);
        check("out_obf", obf_n, 0);
        check("out_oe", pad_oe, 1);
        ack_n = 1'b0; tick(3);
        check("ack_fall_obf", obf_n, 1);
        ack_n = 1'b1; tick(3);
        check("ack_rise_masked", intr, 0);
        inte = 1'b1; #1;
        check("ack_rise_intr", intr, 1);

        // cpu_wr coincident with ack fall: write wins
        cpu_wdata = 8'h96; cpu_wr = 1'b1; tick(1); cpu_wr = 1'b0;
        check("wr_clears_intr", intr, 0);
        ack_n = 1'b0; tick(2);
        cpu_wdata = 8'hE1; cpu_wr = 1'b1; tick(1); cpu_wr = 1'b0;
        check("coin_out_obf", obf_n, 0);
        check("coin_out_pad", pad_out, 8'hE1);
        ack_n = 1'b1; tick(3);
        check("coin_out_hold", obf_n, 0);

        // Control change while O_FULL
        mode = 1'b0; tick(1);
        check("cc_obf", obf_n, 1);
        check("cc_intr", intr, 0);
        check("cc_pad", pad_out, 0);

        // Mode 0 input latency
        dir = 1'b1; tick(1);
        pad_in = 8'hFF; tick(1);
        check("m0_lat1", cpu_rdata, 8'hC3);
        tick(1);
        check("m0_lat2", cpu_rdata, 8'hFF);
        check("m0_ibf", ibf, 0);

        // Disabled port ignores writes
        dir = 1'b0; tick(1);
        port_en = 1'b0; #1;
        check("dis_oe", pad_oe, 0);
        cpu_wdata = 8'hAA; cpu_wr = 1'b1; tick(1); cpu_wr = 1'b0;
        check("dis_wr", pad_out, 0);
        port_en = 1'b1;
        cpu_wr = 1'b1; tick(1); cpu_wr = 1'b0;
        check("m0_wr", pad_out, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ppi_strobed_port.md
Name: ppi_strobed_port

Overview:
- Parametrised PPI data port supporting Mode 0 (basic latched I/O) and Mode 1 (strobed I/O with handshake and interrupt).
- Sits between the internal CPU data bus and one external peripheral port.
- Drives separate pad_out/pad_oe; the tristate buffer sits in the chip top level.
- Successor to the combinational basic-I/O port: adds input/output latches, STB/IBF and OBF/ACK handshakes, INTR and overrun detection.

Parameters:
- WIDTH, 8, port data width in bits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- port_en  input  1  port selected/enabled by control logic.
- mode  input  1  0 = Mode 0 basic, 1 = Mode 1 strobed.
- dir  input  1  1 = input port, 0 = output port.
- inte  input  1  interrupt enable (gates intr).
- cpu_wr  input  1  single-cycle CPU write strobe.
- cpu_rd  input  1  single-cycle CPU read strobe.
- cpu_wdata  input  WIDTH  data from internal bus.
- cpu_rdata  output  WIDTH  data to internal bus.
- pad_in  input  WIDTH  external port pins, sampled.
- pad_out  output  WIDTH  external port drive value.
- pad_oe  output  1  pad output enable.
- stb_n  input  1  peripheral strobe (Mode 1 input), asynchronous.
- ack_n  input  1  peripheral acknowledge (Mode 1 output), asynchronous.
- ibf  output  1  input buffer full.
- obf_n  output  1  output buffer full, active low.
- intr  output  1  interrupt request.
- overrun  output  1  sticky: strobe arrived while ibf=1.

Behaviour:
Reset and control
- Reset values: cpu_rdata=0, pad_out=0, pad_oe=0, ibf=0, obf_n=1, intr=0, overrun=0; FSMs in idle state.
- Reset may assert mid-handshake; it aborts the handshake immediately.
- Control change: any change of mode or dir, detected against registered copies, acts as a synchronous soft reset on the next edge. It clears the latches, ibf, overrun and intr_req, sets obf_n=1, and returns the FSMs to idle.
- pad_oe = port_en & ~dir, combinational from these inputs.
- port_en=0: cpu_rd, cpu_wr and stb/ack edges are ignored; all flags hold.

Synchronisation
- stb_n and ack_n each pass through a 2-flop synchroniser plus an edge detector.
- pad_in passes through an equal 2-flop delay, so captured data aligns with the sampled strobe.
- An edge event fires 3 clk edges after the pin transition.

Interrupt
- intr = intr_req & inte. intr_req is a register that is set and cleared as below, independent of inte.

Mode 0
- Input: cpu_rdata <= delayed pad_in every cycle (2-cycle latency).
- Output: cpu_wr loads out_latch; pad_out = out_latch.
- ibf=0, obf_n=1, intr=0; stb_n and ack_n are ignored.

Mode 1 input (dir=1), FSM I_EMPTY / I_STB / I_FULL
- I_EMPTY, stb fall: in_latch <= delayed pad_in, ibf=1, go to I_STB.
- I_STB, stb rise: intr_req=1, go to I_FULL.
- I_FULL, cpu_rd: ibf=0, intr_req=0, go to I_EMPTY.
- I_STB, cpu_rd: ignored; cpu_rdata = in_latch throughout.
- stb fall while ibf=1 (I_STB or I_FULL): in_latch is overwritten, overrun=1, go to I_STB.
- overrun clears only on a cpu_rd that empties the buffer, or on a control change.
- cpu_rd and stb fall in the same cycle: capture wins. ibf stays 1, intr_req=0, go to I_STB, and overrun is not set.

Mode 1 output (dir=0), FSM O_IDLE / O_FULL / O_ACK
- Any state, cpu_wr: out_latch <= cpu_wdata, obf_n=0, intr_req=0, go to O_FULL.
- O_FULL, ack fall: obf_n=1, go to O_ACK.
- O_ACK, ack rise: intr_req=1, go to O_IDLE.
- cpu_wr and ack fall in the same cycle: write wins, obf_n stays 0, state is O_FULL.
- ack edges in O_IDLE are ignored.
- pad_out = out_latch at all times.

Decomposition:
- ppi_pkg holds:
  - mode encodings MODE_BASIC=0, MODE_STROBED=1;
  - direction encodings DIR_OUT=0, DIR_IN=1;
  - input FSM state constants (2-bit);
  - output FSM state constants (2-bit).
- Sub-module ppi_sync_edge: 2-flop synchroniser with registered rise/fall pulse outputs and reset value 1 (idle high). Instantiated for stb_n and ack_n.

Test Plan:
- Reset release: all outputs at reset values; pad_oe=0 until port_en=1 with dir=0.
- Mode 1 input: pad_in=8'hA5, stb_n low for 4 cycles then high, inte=1.
  - ibf=1 three cycles after the fall; intr=1 three cycles after the rise.
  - cpu_rd returns 8'hA5 and clears ibf and intr on the next edge.
- Overrun: a second strobe with pad_in=8'h3C while ibf=1 -> cpu_rdata=8'h3C, overrun=1; cpu_rd -> ibf=0, overrun=0.
- Mode 1 output: cpu_wr with 8'h5A -> pad_out=8'h5A and obf_n=0; ack_n fall -> obf_n=1; ack_n rise with inte=0 -> intr=0; raise inte -> intr=1.
- Simultaneous events, each case showing no lost data:
  - cpu_wr coincident with an ack fall leaves obf_n=0;
  - cpu_rd coincident with a stb fall leaves ibf=1 with the new data.
- Control change mid-handshake: mode flips 1 -> 0 while in O_FULL -> obf_n=1, intr=0, out_latch=0. Mode 0 input: pad_in=8'hFF appears on cpu_rdata 2 cycles later.
